// File: rtl/nabp_shifter.sv
// Shift-control sequencer for the mapper: one kick pulse, a gated train of
// shift enables (PE back-pressure and abort aware), then one done pulse per pass.
module nabp_shifter #(
   parameter int MAX_SHIFTS = 128,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ss_start,
   input  logic [CNT_W-1:0] ss_shift_count,
   input  logic             ss_abort,
   input  logic             pe_ready,
   output logic             sh_ready,
   output logic             sh_kick,
   output logic             sh_shift_en,
   output logic             sh_done,
   output logic [CNT_W-1:0] sh_shift_idx
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_SHIFTS);

   typedef enum logic [1:0] {
      ready_s,
      kick_s,
      shifting_s,
      done_s
   } state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] len_reg, len_next;
   logic [CNT_W-1:0] idx_reg, idx_next;
   logic             shift_en;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ready_s;
         len_reg   <= '0;
         idx_reg   <= '0;
      end else begin
         state_reg <= state_next;
         len_reg   <= len_next;
         idx_reg   <= idx_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      len_next   = len_reg;
      idx_next   = idx_reg;
      shift_en   = 1'b0;
      case (state_reg)
         ready_s: begin
            if (ss_start) begin
               len_next   = (ss_shift_count > MAX_CNT) ? MAX_CNT : ss_shift_count;
               idx_next   = '0;
               state_next = kick_s;
            end
         end
         kick_s: begin
            state_next = (len_reg != '0) ? shifting_s : done_s;
         end
         shifting_s: begin
            // Abort wins over pe_ready; the last shift leaves idx at len-1 so it never wraps.
            if (ss_abort) begin
               state_next = done_s;
            end else if (pe_ready) begin
               shift_en = 1'b1;
               if (idx_reg == len_reg - 1'b1) begin
                  state_next = done_s;
               end else begin
                  idx_next = idx_reg + 1'b1;
               end
            end
         end
         done_s: begin
            state_next = ready_s;
         end
         default: begin
            state_next = ready_s;
         end
      endcase
   end

   assign sh_ready     = (state_reg == ready_s);
   assign sh_kick      = (state_reg == kick_s);
   assign sh_done      = (state_reg == done_s);
   assign sh_shift_en  = shift_en;
   assign sh_shift_idx = idx_reg;

endmodule

// File: tb/tb_nabp_shifter.sv
// Directed bench for nabp_shifter: stimulus pushes expected kick/shift/done
// events (kind, index, cycle) into a queue; a monitor pops and compares them.
module tb_nabp_shifter;

   localparam int CNT_W   = 8;
   localparam int K_KICK  = 0;
   localparam int K_SHIFT = 1;
   localparam int K_DONE  = 2;

   typedef struct {
      int kind;
      int idx;
      int cyc;
   } ev_t;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             ss_start = 1'b0;
   logic [CNT_W-1:0] ss_shift_count = '0;
   logic             ss_abort = 1'b0;
   logic             pe_ready = 1'b1;
   logic             sh_ready, sh_kick, sh_shift_en, sh_done;
   logic [CNT_W-1:0] sh_shift_idx;

   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   ev_t  exp_q[$];

   nabp_shifter #(.MAX_SHIFTS(128), .CNT_W(CNT_W)) dut (
      .clk            (clk),
      .reset          (reset),
      .ss_start       (ss_start),
      .ss_shift_count (ss_shift_count),
      .ss_abort       (ss_abort),
      .pe_ready       (pe_ready),
      .sh_ready       (sh_ready),
      .sh_kick        (sh_kick),
      .sh_shift_en    (sh_shift_en),
      .sh_done        (sh_done),
      .sh_shift_idx   (sh_shift_idx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got=%0d want=%0d (cycle %0d)", name, act, exp, cyc);
      end else begin
         $display("ok   %s: %0d (cycle %0d)", name, act, cyc);
      end
   endtask

   task automatic push(input int kind, input int idx, input int at);
      ev_t e;
      e.kind = kind;
      e.idx  = idx;
      e.cyc  = at;
      exp_q.push_back(e);
   endtask

   task automatic chk_idle(input string name);
      chk({name, ".ready"}, int'(sh_ready), 1);
      chk({name, ".kick"}, int'(sh_kick), 0);
      chk({name, ".shift_en"}, int'(sh_shift_en), 0);
      chk({name, ".done"}, int'(sh_done), 0);
      chk({name, ".idx"}, int'(sh_shift_idx), 0);
   endtask

   // Monitor: every pulse the DUT presents must match the head of the queue.
   int  m_n, m_kind, m_idx;
   ev_t m_e;
   always @(negedge clk) begin
      if (!reset) begin
         m_n = int'(sh_kick) + int'(sh_shift_en) + int'(sh_done);
         if (m_n > 1) begin
            total++;
            bad++;
            $display("FAIL overlap: kick=%0b shift_en=%0b done=%0b want one-hot (cycle %0d)",
                     sh_kick, sh_shift_en, sh_done, cyc);
         end else if (m_n == 1) begin
            m_kind = sh_kick ? K_KICK : (sh_shift_en ? K_SHIFT : K_DONE);
            m_idx  = sh_shift_en ? int'(sh_shift_idx) : 0;
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected: kind=%0d idx=%0d cycle=%0d want no event",
                        m_kind, m_idx, cyc);
            end else begin
               m_e = exp_q.pop_front();
               if (m_e.kind != m_kind || m_e.idx != m_idx || m_e.cyc != cyc) begin
                  bad++;
                  $display("FAIL event: got kind=%0d idx=%0d cycle=%0d want kind=%0d idx=%0d cycle=%0d",
                           m_kind, m_idx, cyc, m_e.kind, m_e.idx, m_e.cyc);
               end else begin
                  $display("ok   event kind=%0d idx=%0d cycle=%0d", m_kind, m_idx, cyc);
               end
            end
         end
      end
   end

   int t;

   initial begin
      // Reset for 3 cycles
      repeat (3) step();
      reset = 1'b0;
      #2;
      chk_idle("reset");

      // count=4, pe_ready constant; abort during kick must be ignored
      step();
      t = cyc;
      ss_start = 1'b1;
      ss_shift_count = 8'd4;
      push(K_KICK, 0, t + 1);
      for (int i = 0; i < 4; i++) push(K_SHIFT, i, t + 2 + i);
      push(K_DONE, 0, t + 6);
      step();
      ss_start = 1'b0;
      ss_abort = 1'b1;
      step();
      ss_abort = 1'b0;
      repeat (5) step();
      #2;
      chk("c4.ready_t7", int'(sh_ready), 1);

      // count=5 with stalls on the 2nd and 4th shifting cycles
      step();
      t = cyc;
      ss_start = 1'b1;
      ss_shift_count = 8'd5;
      push(K_KICK, 0, t + 1);
      push(K_SHIFT, 0, t + 2);
      push(K_SHIFT, 1, t + 4);
      push(K_SHIFT, 2, t + 6);
      push(K_SHIFT, 3, t + 7);
      push(K_SHIFT, 4, t + 8);
      push(K_DONE, 0, t + 9);
      step();
      ss_start = 1'b0;
      for (int c = t + 1; c <= t + 9; c++) begin
         pe_ready = !(c == t + 3 || c == t + 5);
         #2;
         if (c == t + 3) begin
            chk("c5.stall1.shift_en", int'(sh_shift_en), 0);
            chk("c5.stall1.idx", int'(sh_shift_idx), 1);
         end
         if (c == t + 5) begin
            chk("c5.stall2.shift_en", int'(sh_shift_en), 0);
            chk("c5.stall2.idx", int'(sh_shift_idx), 2);
         end
         step();
      end
      pe_ready = 1'b1;
      #2;
      chk("c5.ready", int'(sh_ready), 1);

      // count=0: kick then done, no shifts
      step();
      t = cyc;
      ss_start = 1'b1;
      ss_shift_count = 8'd0;
      push(K_KICK, 0, t + 1);
      push(K_DONE, 0, t + 2);
      step();
      ss_start = 1'b0;
      repeat (2) step();
      #2;
      chk("c0.ready", int'(sh_ready), 1);

      // count=128, mid-pass start ignored, abort after 10 shifts
      step();
      t = cyc;
      ss_start = 1'b1;
      ss_shift_count = 8'd128;
      push(K_KICK, 0, t + 1);
      for (int i = 0; i < 10; i++) push(K_SHIFT, i, t + 2 + i);
      push(K_DONE, 0, t + 13);
      step();
      for (int c = t + 1; c <= t + 13; c++) begin
         ss_start = (c == t + 6);
         ss_shift_count = 8'd3;
         ss_abort = (c == t + 12);
         if (c == t + 12) begin
            #2;
            chk("abort.shift_en", int'(sh_shift_en), 0);
         end
         step();
      end
      ss_start = 1'b0;
      ss_abort = 1'b0;
      #2;
      chk("abort.ready", int'(sh_ready), 1);

      // count=255 saturates to 128 shifts
      step();
      t = cyc;
      ss_start = 1'b1;
      ss_shift_count = 8'd255;
      push(K_KICK, 0, t + 1);
      for (int i = 0; i < 128; i++) push(K_SHIFT, i, t + 2 + i);
      push(K_DONE, 0, t + 130);
      step();
      ss_start = 1'b0;
      repeat (130) step();
      #2;
      chk("sat.ready", int'(sh_ready), 1);

      // Reset mid-pass at idx=7, then a clean count=2 pass
      step();
      t = cyc;
      ss_start = 1'b1;
      ss_shift_count = 8'd20;
      push(K_KICK, 0, t + 1);
      for (int i = 0; i < 7; i++) push(K_SHIFT, i, t + 2 + i);
      step();
      ss_start = 1'b0;
      repeat (8) step();
      #2;
      chk("rst_mid.idx_before", int'(sh_shift_idx), 7);
      reset = 1'b1;
      step();
      reset = 1'b0;
      #2;
      chk_idle("rst_mid");
      t = cyc;
      ss_start = 1'b1;
      ss_shift_count = 8'd2;
      push(K_KICK, 0, t + 1);
      push(K_SHIFT, 0, t + 2);
      push(K_SHIFT, 1, t + 3);
      push(K_DONE, 0, t + 4);
      step();
      ss_start = 1'b0;
      repeat (4) step();
      #2;
      chk("post_rst.ready", int'(sh_ready), 1);

      repeat (3) step();
      chk("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
